// File: rtl/morse_tim_ctrl.sv
// -----------------------------------------------------------------------------
// morse_tim_ctrl
// Keying timer for the Morse translator. Measures mark and space lengths of a
// debounced key level in Morse units and classifies them into symbols (dot,
// dash, character end, word end) that are handed to the decoder through a
// one-entry valid/ready buffer.
//
// Ports:
//   clk       in   system clock, rising edge
//   nrst      in   asynchronous active-low reset
//   key       in   debounced key level, synchronous to clk (1 = key down)
//   sym_ready in   decoder accepts the buffered symbol
//   sym_valid out  buffer holds a symbol
//   sym_code  out  00 dot, 01 dash, 10 char end, 11 word end
//   busy      out  FSM is not idle
//   ovf       out  sticky: a symbol was dropped because the buffer was full
// -----------------------------------------------------------------------------
module morse_tim_ctrl #(
  parameter int unsigned UNIT   = 1000,
  parameter int unsigned PW     = 16,
  parameter int unsigned UW     = 4,
  parameter int unsigned DASH_U = 2,
  parameter int unsigned CHAR_U = 2,
  parameter int unsigned WORD_U = 5
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       key,
  input  logic       sym_ready,
  output logic       sym_valid,
  output logic [1:0] sym_code,
  output logic       busy,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  localparam logic [1:0] CODE_DOT  = 2'b00;
  localparam logic [1:0] CODE_DASH = 2'b01;
  localparam logic [1:0] CODE_CHAR = 2'b10;
  localparam logic [1:0] CODE_WORD = 2'b11;

  localparam logic [PW-1:0] PRE_LAST = PW'(UNIT - 1);
  localparam logic [UW-1:0] U_MAX    = {UW{1'b1}};
  localparam logic [UW-1:0] DASH_T   = UW'(DASH_U);
  localparam logic [UW-1:0] CHAR_T   = UW'(CHAR_U);
  localparam logic [UW-1:0] WORD_T   = UW'(WORD_U);

  // The edge cycle itself is the first cycle of the new level, so the counters
  // restart at a count of one cycle (already a full unit when UNIT is 1).
  localparam logic [PW-1:0] START_PRE = (UNIT == 1) ? {PW{1'b0}} : PW'(1);
  localparam logic [UW-1:0] START_U   = (UNIT == 1) ? UW'(1) : {UW{1'b0}};

  logic          key_q_r;
  state_t        state_r;
  state_t        state_nxt_s;
  logic [PW-1:0] pre_r;
  logic [UW-1:0] u_r;
  logic [PW-1:0] pre_inc_s;
  logic [UW-1:0] u_inc_s;
  logic          rise_s;
  logic          fall_s;
  logic          push_s;
  logic [1:0]    push_code_s;
  logic          sym_valid_r;
  logic [1:0]    sym_code_r;
  logic          busy_r;
  logic          ovf_r;

  assign rise_s = key & ~key_q_r;
  assign fall_s = ~key & key_q_r;

  assign sym_valid = sym_valid_r;
  assign sym_code  = sym_code_r;
  assign busy      = busy_r;
  assign ovf       = ovf_r;

  // Count including the current cycle: restart on an edge, otherwise advance
  // the prescaler and bump the saturating unit counter on each wrap.
  always_comb begin
    pre_inc_s = pre_r;
    u_inc_s   = u_r;
    if (rise_s || fall_s) begin
      pre_inc_s = START_PRE;
      u_inc_s   = START_U;
    end else if (pre_r == PRE_LAST) begin
      pre_inc_s = {PW{1'b0}};
      if (u_r != U_MAX) begin
        u_inc_s = u_r + UW'(1);
      end else begin
        u_inc_s = u_r;
      end
    end else begin
      pre_inc_s = pre_r + PW'(1);
    end
  end

  // Next-state and symbol push decode.
  always_comb begin
    state_nxt_s = state_r;
    push_s      = 1'b0;
    push_code_s = CODE_DOT;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          state_nxt_s = MARK;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MARK: begin
        // On the fall cycle the registered count still holds the full mark.
        if (fall_s) begin
          push_s      = 1'b1;
          push_code_s = (u_r >= DASH_T) ? CODE_DASH : CODE_DOT;
          state_nxt_s = SPACE;
        end else begin
          state_nxt_s = MARK;
        end
      end
      SPACE: begin
        // A count that lands exactly on a unit boundary happens once per
        // threshold, so char end cannot repeat within one space.
        if (rise_s) begin
          state_nxt_s = MARK;
        end else if ((u_inc_s == WORD_T) && (pre_inc_s == {PW{1'b0}})) begin
          push_s      = 1'b1;
          push_code_s = CODE_WORD;
          state_nxt_s = IDLE;
        end else if ((u_inc_s == CHAR_T) && (pre_inc_s == {PW{1'b0}})) begin
          push_s      = 1'b1;
          push_code_s = CODE_CHAR;
          state_nxt_s = SPACE;
        end else begin
          state_nxt_s = SPACE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Key history, FSM state, counters and busy flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      key_q_r <= 1'b0;
      state_r <= IDLE;
      pre_r   <= {PW{1'b0}};
      u_r     <= {UW{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      key_q_r <= key;
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      if (state_nxt_s == IDLE) begin
        pre_r <= {PW{1'b0}};
        u_r   <= {UW{1'b0}};
      end else begin
        pre_r <= pre_inc_s;
        u_r   <= u_inc_s;
      end
    end
  end

  // One-entry symbol buffer; a push into a full buffer that is not being
  // popped in the same cycle is dropped and latches the overflow flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sym_valid_r <= 1'b0;
      sym_code_r  <= CODE_DOT;
      ovf_r       <= 1'b0;
    end else begin
      if (push_s) begin
        if (!sym_valid_r || sym_ready) begin
          sym_valid_r <= 1'b1;
          sym_code_r  <= push_code_s;
        end else begin
          ovf_r <= 1'b1;
        end
      end else if (sym_valid_r && sym_ready) begin
        sym_valid_r <= 1'b0;
      end else begin
        sym_valid_r <= sym_valid_r;
      end
    end
  end

endmodule

// File: doc/morse_tim_ctrl.md
# morse_tim_ctrl

Keying timer controller for the Morse translator. It watches a synchronous, debounced key level and runs its own prescaler and unit counter, restarting them on every key edge. It measures mark and space durations in Morse units and classifies each into a symbol: dot, dash, character end or word end. Symbols go to the decoder through a one-entry valid/ready buffer.

## Interface
- UNIT, default 1000: clock cycles per Morse unit (1 ≤ UNIT ≤ 2^PW).
- PW, default 16: prescaler width.
- UW, default 4: unit counter width. Saturates at 2^UW−1.
- DASH_U, default 2: a mark of at least DASH_U units is a dash.
- CHAR_U, default 2: a space of CHAR_U units ends a character.
- WORD_U, default 5: a space of WORD_U units ends a word. Requires CHAR_U < WORD_U ≤ 2^UW−1.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous, active-low reset.
- key  in  1  debounced key level, synchronous to clk (1 = key down).
- sym_ready  in  1  decoder accepts the symbol.
- sym_valid  out  1  symbol buffer holds a symbol.
- sym_code  out  2  symbol code: 00 dot, 01 dash, 10 char end, 11 word end.
- busy  out  1  high when the FSM is not in IDLE.
- ovf  out  1  sticky flag: a symbol was dropped because the buffer was full.

## Operation
- key_q holds key registered by one cycle.
  - Rise = key & ~key_q.
  - Fall = ~key & key_q.
- Mark length N is the number of consecutive cycles with key = 1.
- Space length L is the number of consecutive cycles with key = 0 since the last fall.
- Counters:
  - The prescaler counts cycles modulo UNIT. On each wrap it increments the unit counter.
  - Both counters restart on every detected edge, so that the counts equal N or L as defined above.
  - The unit counter saturates and never wraps.
- FSM states: IDLE, MARK, SPACE.
  - IDLE: counters are held at 0. On rise, go to MARK.
  - MARK: on fall, push a symbol and go to SPACE. The symbol is dash if N ≥ DASH_U·UNIT, otherwise dot.
  - SPACE, on rise: go to MARK. No symbol is pushed.
  - SPACE, on the cycle L reaches CHAR_U·UNIT: push char end. Push it once per space.
  - SPACE, on the cycle L reaches WORD_U·UNIT: push word end and go to IDLE.
- Symbol buffer (one entry):
  - A push is accepted if the buffer is empty, or if sym_valid & sym_ready in the same cycle (pop and push together, so sym_valid stays high).
  - Otherwise the new symbol is dropped, the old symbol is kept and ovf is set.
  - ovf is cleared only by nrst.
- A pop (sym_valid & sym_ready) with no push clears sym_valid.
- busy = (state != IDLE).

## Timing
- Reset values: state IDLE, key_q 0, counters 0, sym_valid 0, sym_code 00, busy 0, ovf 0.
- Push latency: sym_valid and sym_code update on the clock edge that ends the push cycle. They are visible one cycle after that cycle.
  - Dot/dash: the push cycle is the fall-detect cycle, the first cycle with key = 0.
  - Char end / word end: the push cycle is the L-th low cycle.
- busy rises the cycle after the rise-detect cycle. It falls the cycle after the word-end push cycle.
- sym_code is stable while sym_valid = 1 and sym_ready = 0.
- Reset mid-operation: all state clears asynchronously and any pending symbol is lost. If key = 1 at reset release, the first clock detects a rise and starts a fresh mark.
- Very long mark: the unit counter saturates and the symbol is still a dash.
- A rise after the char-end push but before the word end returns to MARK. No word end is pushed.
- A mark of one cycle is a dot.

## Test plan
Use UNIT=4, DASH_U=2, CHAR_U=2, WORD_U=5, with sym_ready=1 unless a scenario says otherwise.
- Dot/dash boundary:
  - key high 7 cycles → one sym_valid pulse with code 00.
  - key high 8 cycles → code 01, one cycle after the fall-detect cycle.
- Char-end boundary:
  - Mark, then key low 7 cycles, then high → only the mark symbol is emitted.
  - Key low 8 cycles → code 10 is emitted after the 8th low cycle. busy stays 1.
- Word end:
  - Mark, then key low 20 cycles → codes 00/01, then 10 at L=8, then 11 at L=20.
  - busy drops the cycle after the word-end push cycle. No further symbols follow.
- Backpressure and overflow:
  - sym_ready=0, then two marks → the first symbol is held with a stable code, the second is dropped and ovf=1.
  - Raising sym_ready → the held symbol is popped. ovf stays 1 until nrst.
- Simultaneous pop and push: with sym_valid=1 and sym_ready=1 on a fall-detect cycle → the new code appears next cycle, sym_valid stays 1 and ovf stays 0.
- Reset mid-mark:
  - Assert nrst after 5 high cycles, release with key=1 → all outputs are at reset values during reset.
  - The mark restarts on release. Holding key 8 more cycles → code 01.
